// File: rtl/osiris_pkg.sv
// Shared encodings for the memory-stage load/store unit.
package osiris_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store enables/replication, load extraction/extension,
// and misalignment detection. Purely combinational.
module lsu_align
  import osiris_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [1:0]            i_addr_lo,
  input  logic [2:0]            i_funct3,
  input  logic                  i_is_store,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic [3:0]            o_be_c,
  output logic [DATA_WIDTH-1:0] o_wdata_c,
  output logic [DATA_WIDTH-1:0] o_rdata_c,
  output logic                  o_misaligned_c
);

  localparam int unsigned NLANE = DATA_WIDTH / 8;

  logic        w_byte;
  logic        w_half;
  logic [15:0] w_lane;

  always_comb begin
    w_byte = (i_funct3 == F3_B) || (i_funct3 == F3_BU);
    w_half = (i_funct3 == F3_H) || (i_funct3 == F3_HU);
    // Anything that is neither byte nor halfword (incl. 011/110/111) is a word access
    o_misaligned_c = w_half ? i_addr_lo[0] : (!w_byte && (i_addr_lo != 2'b00));

    o_be_c    = 4'b1111;
    o_wdata_c = i_wdata;
    if (i_is_store && w_byte) begin
      o_be_c    = 4'b0001 << i_addr_lo;
      o_wdata_c = {NLANE{i_wdata[7:0]}};
    end else if (i_is_store && w_half) begin
      o_be_c    = 4'b0011 << {i_addr_lo[1], 1'b0};
      o_wdata_c = {(NLANE / 2){i_wdata[15:0]}};
    end

    w_lane = 16'(i_rdata >> {i_addr_lo, 3'b000});
    case (i_funct3)
      F3_B:    o_rdata_c = {{(DATA_WIDTH - 8){w_lane[7]}}, w_lane[7:0]};
      F3_BU:   o_rdata_c = {{(DATA_WIDTH - 8){1'b0}}, w_lane[7:0]};
      F3_H:    o_rdata_c = {{(DATA_WIDTH - 16){w_lane[15]}}, w_lane};
      F3_HU:   o_rdata_c = {{(DATA_WIDTH - 16){1'b0}}, w_lane};
      F3_W:    o_rdata_c = i_rdata;
      default: o_rdata_c = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: one single-outstanding req/ack bus transaction per access,
// stalling the pipeline until it completes or times out.
module mem_stage_lsu
  import osiris_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_WIDTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_alu_result_M,
  input  logic [DATA_WIDTH-1:0] i_write_data_M,
  input  logic                  i_mem_write_M,
  input  logic [1:0]            i_result_src_M,
  input  logic [2:0]            i_funct3_M,
  output logic                  o_dmem_req,
  output logic                  o_dmem_we,
  output logic [DATA_WIDTH-1:0] o_dmem_addr,
  output logic [DATA_WIDTH-1:0] o_dmem_wdata,
  output logic [3:0]            o_dmem_be,
  input  logic                  i_dmem_ack,
  input  logic [DATA_WIDTH-1:0] i_dmem_rdata,
  output logic [DATA_WIDTH-1:0] o_read_data_M,
  output logic                  o_stall_M,
  output logic                  o_misaligned_M,
  output logic                  o_bus_err_M
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_t            r_state;
  lsu_state_t            w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic                  w_access;
  logic                  w_start;
  logic                  w_timeout;
  logic [3:0]            w_be_c;
  logic [DATA_WIDTH-1:0] w_wdata_c;
  logic [DATA_WIDTH-1:0] w_rdata_c;
  logic                  w_misaligned_c;
  // Destination index travels alongside the pipeline register, not through this unit
  logic [REG_WIDTH-1:0]  w_unused_rd_idx;

  assign w_unused_rd_idx = '0;

  lsu_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_align (
    .i_addr_lo     (i_alu_result_M[1:0]),
    .i_funct3      (i_funct3_M),
    .i_is_store    (i_mem_write_M),
    .i_wdata       (i_write_data_M),
    .i_rdata       (i_dmem_rdata),
    .o_be_c        (w_be_c),
    .o_wdata_c     (w_wdata_c),
    .o_rdata_c     (w_rdata_c),
    .o_misaligned_c(w_misaligned_c)
  );

  assign w_access  = i_mem_write_M || (i_result_src_M == RESULT_SRC_MEM);
  assign w_start   = (r_state == IDLE) && w_access && !w_misaligned_c;
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign o_stall_M = !rst && (w_start || (r_state == REQ));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_nxt = REQ;
      REQ:     if (i_dmem_ack || w_timeout) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Bus fields, result and status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      o_dmem_req     <= 1'b0;
      o_dmem_we      <= 1'b0;
      o_dmem_addr    <= '0;
      o_dmem_wdata   <= '0;
      o_dmem_be      <= 4'b0000;
      o_read_data_M  <= '0;
      o_misaligned_M <= 1'b0;
      o_bus_err_M    <= 1'b0;
      r_cnt          <= '0;
    end else begin
      o_misaligned_M <= (r_state == IDLE) && w_access && w_misaligned_c;
      o_bus_err_M    <= (r_state == REQ) && !i_dmem_ack && w_timeout;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            o_dmem_req   <= 1'b1;
            o_dmem_we    <= i_mem_write_M;
            o_dmem_addr  <= {i_alu_result_M[DATA_WIDTH-1:2], 2'b00};
            o_dmem_wdata <= w_wdata_c;
            o_dmem_be    <= w_be_c;
            r_cnt        <= '0;
          end
        end
        REQ: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (i_dmem_ack) begin
            o_dmem_req <= 1'b0;
            if (!o_dmem_we) o_read_data_M <= w_rdata_c;
          end else if (w_timeout) begin
            o_dmem_req    <= 1'b0;
            o_read_data_M <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu.
`timescale 1ns/1ps
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_alu_result_M;
  logic [31:0] i_write_data_M;
  logic        i_mem_write_M;
  logic [1:0]  i_result_src_M;
  logic [2:0]  i_funct3_M;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic [31:0] o_dmem_addr;
  logic [31:0] o_dmem_wdata;
  logic [3:0]  o_dmem_be;
  logic        i_dmem_ack;
  logic [31:0] i_dmem_rdata;
  logic [31:0] o_read_data_M;
  logic        o_stall_M;
  logic        o_misaligned_M;
  logic        o_bus_err_M;

  int n_tests = 0;
  int n_fail  = 0;

  int          c_stalls;
  int          c_reqs;
  logic [31:0] c_rd;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic [3:0]  c_be;
  logic        c_we;
  logic        c_berr;
  logic        c_done;

  mem_stage_lsu dut (
    .clk           (clk),
    .rst           (rst),
    .i_alu_result_M(i_alu_result_M),
    .i_write_data_M(i_write_data_M),
    .i_mem_write_M (i_mem_write_M),
    .i_result_src_M(i_result_src_M),
    .i_funct3_M    (i_funct3_M),
    .o_dmem_req    (o_dmem_req),
    .o_dmem_we     (o_dmem_we),
    .o_dmem_addr   (o_dmem_addr),
    .o_dmem_wdata  (o_dmem_wdata),
    .o_dmem_be     (o_dmem_be),
    .i_dmem_ack    (i_dmem_ack),
    .i_dmem_rdata  (i_dmem_rdata),
    .o_read_data_M (o_read_data_M),
    .o_stall_M     (o_stall_M),
    .o_misaligned_M(o_misaligned_M),
    .o_bus_err_M   (o_bus_err_M)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got running required finished");
    $fatal(1);
  end

  task automatic clear_inputs();
    i_alu_result_M = '0;
    i_write_data_M = '0;
    i_mem_write_M  = 1'b0;
    i_result_src_M = 2'b00;
    i_funct3_M     = 3'b000;
    i_dmem_ack     = 1'b0;
    i_dmem_rdata   = '0;
  endtask

  // Drives one access from IDLE through DONE; ack_at = REQ cycle carrying ack (0 = never)
  task automatic run_access(input logic [31:0] addr, input logic [31:0] wdata, input logic mw,
                            input logic [1:0] rsrc, input logic [2:0] f3, input int ack_at,
                            input logic [31:0] rdata);
    int k;
    k = 0;
    c_stalls = 0; c_reqs = 0; c_rd = '0; c_addr = '0; c_wdata = '0; c_be = '0;
    c_we = 1'b0; c_berr = 1'b0; c_done = 1'b0;
    i_alu_result_M = addr;
    i_write_data_M = wdata;
    i_mem_write_M  = mw;
    i_result_src_M = rsrc;
    i_funct3_M     = f3;
    for (int c = 0; c < 600 && !c_done; c++) begin
      if (o_dmem_req) k++;
      i_dmem_ack   = o_dmem_req && (k == ack_at);
      i_dmem_rdata = rdata;
      @(negedge clk);
      if (o_dmem_req && k == 1) begin
        c_addr = o_dmem_addr; c_wdata = o_dmem_wdata; c_be = o_dmem_be; c_we = o_dmem_we;
      end
      if (o_stall_M) c_stalls++;
      if (o_dmem_req) c_reqs++;
      if (o_bus_err_M) c_berr = 1'b1;
      if (!o_stall_M && c_stalls > 0) begin
        c_done = 1'b1;
        c_rd   = o_read_data_M;
      end
      @(posedge clk); #1;
    end
    clear_inputs();
    n_tests++;
    if (c_done !== 1'b1) begin
      n_fail++;
      $display("FAIL access_budget addr=%h: done=%b required 1", addr, c_done);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if ({o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_be, o_read_data_M,
         o_stall_M, o_misaligned_M, o_bus_err_M} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: req=%b we=%b addr=%h wdata=%h be=%b rd=%h stall=%b required all 0",
               o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_be, o_read_data_M, o_stall_M);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({o_dmem_req, o_stall_M} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_after_reset: req=%b stall=%b required 0 0", o_dmem_req, o_stall_M);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_lw();
    run_access(32'h100, 32'h0, 1'b0, 2'b01, 3'b010, 1, 32'hDEADBEEF);
    n_tests++;
    if ({c_stalls, c_reqs} !== {32'd2, 32'd1}) begin
      n_fail++;
      $display("FAIL lw_latency: stalls=%0d reqs=%0d required 2 1", c_stalls, c_reqs);
    end
    n_tests++;
    if ({c_addr, c_be, c_we} !== {32'h100, 4'b1111, 1'b0}) begin
      n_fail++;
      $display("FAIL lw_bus: addr=%h be=%b we=%b required 00000100 1111 0", c_addr, c_be, c_we);
    end
    n_tests++;
    if (c_rd !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL lw_data: got %h required deadbeef", c_rd);
    end
  endtask

  task automatic test_sb();
    run_access(32'h203, 32'h000000A5, 1'b1, 2'b00, 3'b000, 3, 32'h12345678);
    n_tests++;
    if ({c_stalls, c_reqs} !== {32'd4, 32'd3}) begin
      n_fail++;
      $display("FAIL sb_latency: stalls=%0d reqs=%0d required 4 3", c_stalls, c_reqs);
    end
    n_tests++;
    if ({c_addr, c_be, c_wdata, c_we} !== {32'h200, 4'b1000, 32'hA5A5A5A5, 1'b1}) begin
      n_fail++;
      $display("FAIL sb_bus: addr=%h be=%b wdata=%h we=%b required 00000200 1000 a5a5a5a5 1",
               c_addr, c_be, c_wdata, c_we);
    end
    n_tests++;
    if (c_rd !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL sb_keeps_rdata: got %h required deadbeef", c_rd);
    end
  endtask

  task automatic test_sh_priority();
    // Store and load both flagged: store wins, read data must not change
    run_access(32'h106, 32'hFFFF1234, 1'b1, 2'b01, 3'b001, 1, 32'h55555555);
    n_tests++;
    if ({c_addr, c_be, c_wdata, c_we} !== {32'h104, 4'b1100, 32'h12341234, 1'b1}) begin
      n_fail++;
      $display("FAIL sh_bus: addr=%h be=%b wdata=%h we=%b required 00000104 1100 12341234 1",
               c_addr, c_be, c_wdata, c_we);
    end
    n_tests++;
    if (c_rd !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL sh_priority_rdata: got %h required deadbeef", c_rd);
    end
  endtask

  task automatic test_load_ext();
    logic [31:0] t_addr [6] = '{32'h101, 32'h101, 32'h102, 32'h102, 32'h010, 32'h203};
    logic [2:0]  t_f3   [6] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b011, 3'b000};
    logic [31:0] t_rd   [6] = '{32'h00008000, 32'h00008000, 32'hBEEF0000, 32'hBEEF0000,
                                32'hCAFEF00D, 32'h80000000};
    logic [31:0] t_exp  [6] = '{32'hFFFFFF80, 32'h00000080, 32'h0000BEEF, 32'hFFFFBEEF,
                                32'hCAFEF00D, 32'hFFFFFF80};
    for (int i = 0; i < 6; i++) begin
      run_access(t_addr[i], 32'h0, 1'b0, 2'b01, t_f3[i], 1, t_rd[i]);
      n_tests++;
      if ({c_rd, c_be} !== {t_exp[i], 4'b1111}) begin
        n_fail++;
        $display("FAIL load_ext[%0d] f3=%b addr=%h: rd=%h be=%b required %h 1111",
                 i, t_f3[i], t_addr[i], c_rd, c_be, t_exp[i]);
      end
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] t_addr [3] = '{32'h101, 32'h102, 32'h003};
    logic [2:0]  t_f3   [3] = '{3'b001, 3'b010, 3'b110};
    logic        t_mw   [3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      i_alu_result_M = t_addr[i];
      i_funct3_M     = t_f3[i];
      i_mem_write_M  = t_mw[i];
      i_result_src_M = t_mw[i] ? 2'b00 : 2'b01;
      @(negedge clk);
      n_tests++;
      if ({o_stall_M, o_dmem_req} !== 2'b00) begin
        n_fail++;
        $display("FAIL mis_nostall[%0d]: stall=%b req=%b required 0 0", i, o_stall_M, o_dmem_req);
      end
      @(posedge clk); #1;
      clear_inputs();
      @(negedge clk);
      n_tests++;
      if ({o_misaligned_M, o_dmem_req, o_stall_M} !== 3'b100) begin
        n_fail++;
        $display("FAIL mis_pulse[%0d]: mis=%b req=%b stall=%b required 1 0 0",
                 i, o_misaligned_M, o_dmem_req, o_stall_M);
      end
      @(posedge clk); #1;
      @(negedge clk);
      n_tests++;
      if ({o_misaligned_M, o_dmem_req} !== 2'b00) begin
        n_fail++;
        $display("FAIL mis_one_cycle[%0d]: mis=%b req=%b required 0 0", i, o_misaligned_M, o_dmem_req);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    run_access(32'h300, 32'h0, 1'b0, 2'b01, 3'b010, 0, 32'h11111111);
    n_tests++;
    if ({c_reqs, c_stalls} !== {32'd255, 32'd256}) begin
      n_fail++;
      $display("FAIL timeout_len: reqs=%0d stalls=%0d required 255 256", c_reqs, c_stalls);
    end
    n_tests++;
    if ({c_berr, c_rd} !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL timeout_err: berr=%b rd=%h required 1 00000000", c_berr, c_rd);
    end
    @(negedge clk);
    n_tests++;
    if ({o_bus_err_M, o_stall_M, o_dmem_req} !== 3'b000) begin
      n_fail++;
      $display("FAIL timeout_pulse_end: berr=%b stall=%b req=%b required 0 0 0",
               o_bus_err_M, o_stall_M, o_dmem_req);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    run_access(32'h40A, 32'h0, 1'b0, 2'b01, 3'b101, 1, 32'h9ABC0000);
    n_tests++;
    if ({c_rd, c_stalls} !== {32'h00009ABC, 32'd2}) begin
      n_fail++;
      $display("FAIL b2b_first: rd=%h stalls=%0d required 00009abc 2", c_rd, c_stalls);
    end
    run_access(32'h408, 32'h0, 1'b0, 2'b01, 3'b010, 2, 32'h0BADF00D);
    n_tests++;
    if ({c_rd, c_stalls, c_addr} !== {32'h0BADF00D, 32'd3, 32'h408}) begin
      n_fail++;
      $display("FAIL b2b_second: rd=%h stalls=%0d addr=%h required 0badf00d 3 00000408",
               c_rd, c_stalls, c_addr);
    end
  endtask

  task automatic test_reset_in_req();
    i_alu_result_M = 32'h500;
    i_result_src_M = 2'b01;
    i_funct3_M     = 3'b010;
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if ({o_dmem_req, o_stall_M} !== 2'b11) begin
      n_fail++;
      $display("FAIL rst_req_enter: req=%b stall=%b required 1 1", o_dmem_req, o_stall_M);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    clear_inputs();
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if ({o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_read_data_M, o_stall_M,
         o_bus_err_M, o_misaligned_M} !== '0) begin
      n_fail++;
      $display("FAIL rst_in_req: req=%b addr=%h be=%b rd=%h stall=%b required all 0",
               o_dmem_req, o_dmem_addr, o_dmem_be, o_read_data_M, o_stall_M);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    i_dmem_ack   = 1'b1;
    i_dmem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    i_dmem_ack = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({o_dmem_req, o_read_data_M, o_stall_M, o_bus_err_M} !== '0) begin
      n_fail++;
      $display("FAIL stray_ack: req=%b rd=%h stall=%b berr=%b required all 0",
               o_dmem_req, o_read_data_M, o_stall_M, o_bus_err_M);
    end
    @(posedge clk); #1;
    run_access(32'h600, 32'h0, 1'b0, 2'b01, 3'b010, 1, 32'h13579BDF);
    n_tests++;
    if ({c_rd, c_stalls} !== {32'h13579BDF, 32'd2}) begin
      n_fail++;
      $display("FAIL post_reset_lw: rd=%h stalls=%0d required 13579bdf 2", c_rd, c_stalls);
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_lw();
    test_sb();
    test_sh_priority();
    test_load_ext();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_reset_in_req();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
